// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard/sequencing bundle between the datapath and pipeline_hazard_ctrl.
// The master side is the datapath, which drives the hazard and debug requests.
// The slave side is the controller, which returns the stall/flush/debug status.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_d_i;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_d_i;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_e_i;
  logic [1:0]                result_src_e_i;
  logic                      pc_src_e_i;
  logic                      halt_req_i;
  logic                      resume_req_i;
  logic                      step_req_i;
  logic                      stall_f_o;
  logic                      stall_d_o;
  logic                      flush_d_o;
  logic                      flush_e_o;
  logic                      halted_o;
  logic                      step_done_o;

  modport master (
    output rs1_addr_d_i, rs2_addr_d_i, rd_addr_e_i, result_src_e_i, pc_src_e_i,
    output halt_req_i, resume_req_i, step_req_i,
    input  stall_f_o, stall_d_o, flush_d_o, flush_e_o, halted_o, step_done_o
  );

  modport slave (
    input  rs1_addr_d_i, rs2_addr_d_i, rd_addr_e_i, result_src_e_i, pc_src_e_i,
    input  halt_req_i, resume_req_i, step_req_i,
    output stall_f_o, stall_d_o, flush_d_o, flush_e_o, halted_o, step_done_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing for the five-stage RV32 pipeline.
// It applies a post-reset front-end flush, load-use stalls and branch/jump
// redirects.
// Optional debug halt/single-step is built when PIPELINE_HAZARD_CTRL_DEBUG_EN
// is defined. Without that macro, only INIT and RUN exist and the debug
// outputs read 0.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH     = 5,
  parameter int RESET_FLUSH_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

`ifdef PIPELINE_HAZARD_CTRL_DEBUG_EN
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, HALTED = 2'd2, STEP = 2'd3} state_t;
`else
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
`endif

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] flush_cnt_reg;
  logic       lw_stall;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;

  // Load in Execute writing a register Decode wants; a redirect squashes Decode anyway.
  assign lw_stall = (bus.result_src_e_i == 2'b01)
                  && (bus.rd_addr_e_i != '0)
                  && ((bus.rd_addr_e_i == bus.rs1_addr_d_i) || (bus.rd_addr_e_i == bus.rs2_addr_d_i))
                  && !bus.pc_src_e_i;

`ifdef PIPELINE_HAZARD_CTRL_DEBUG_EN
  logic halt_pending_reg;
  logic step_done_reg;
`else
  logic unused_debug_inputs;
  assign unused_debug_inputs = &{1'b0, bus.halt_req_i, bus.resume_req_i, bus.step_req_i};
`endif

  // State register; reset always returns to the flush sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Flush counter; loaded at reset and counted down only while INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_reg <= 4'(RESET_FLUSH_CYCLES);
    end else if (state_reg == INIT && flush_cnt_reg != 4'd0) begin
      flush_cnt_reg <= flush_cnt_reg - 4'd1;
    end
  end

  // Next-state and stall/flush decode; outputs are combinational on hazard inputs.
  always_comb begin
    state_next = state_reg;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    case (state_reg)
      INIT: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        if (flush_cnt_reg == 4'd1) begin
          state_next = RUN;
        end
      end
      RUN: begin
        stall_f = lw_stall;
        stall_d = lw_stall;
        flush_d = bus.pc_src_e_i;
        flush_e = lw_stall | bus.pc_src_e_i;
`ifdef PIPELINE_HAZARD_CTRL_DEBUG_EN
        // Halt only on a clean cycle so no stall or redirect is lost.
        if ((halt_pending_reg || bus.halt_req_i) && !lw_stall && !bus.pc_src_e_i) begin
          state_next = HALTED;
        end
`endif
      end
`ifdef PIPELINE_HAZARD_CTRL_DEBUG_EN
      HALTED: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        if (bus.resume_req_i) begin
          state_next = RUN;
        end else if (bus.step_req_i) begin
          state_next = STEP;
        end
      end
      STEP: begin
        stall_f = lw_stall;
        stall_d = lw_stall;
        flush_d = bus.pc_src_e_i;
        flush_e = lw_stall | bus.pc_src_e_i;
        if (!lw_stall) begin
          state_next = HALTED;
        end
      end
`endif
      default: state_next = INIT;
    endcase
  end

`ifdef PIPELINE_HAZARD_CTRL_DEBUG_EN
  // Remember a halt request seen in RUN until a clean cycle lets it take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_pending_reg <= 1'b0;
    end else if (state_reg == RUN && state_next == HALTED) begin
      halt_pending_reg <= 1'b0;
    end else if (state_reg == RUN && bus.halt_req_i) begin
      halt_pending_reg <= 1'b1;
    end
  end

  // Flag the first HALTED cycle after a completed step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_done_reg <= 1'b0;
    end else begin
      step_done_reg <= (state_reg == STEP) && (state_next == HALTED);
    end
  end

  assign bus.halted_o    = (state_reg == HALTED);
  assign bus.step_done_o = step_done_reg;
`else
  assign bus.halted_o    = 1'b0;
  assign bus.step_done_o = 1'b0;
`endif

  assign bus.stall_f_o = stall_f;
  assign bus.stall_d_o = stall_d;
  assign bus.flush_d_o = flush_d;
  assign bus.flush_e_o = flush_e;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the RV32 five-stage core. It generates the stall and flush controls for the IF/ID register, PC register and ID/EX register. Sources are a post-reset flush sequence, load-use hazard detection between Decode and Execute, and taken-branch/jump redirects from Execute. An optional debug halt/single-step state machine freezes the front end while downstream stages drain.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, default 5: register address width; matches the codebase define.
- `RESET_FLUSH_CYCLES`, default 2, range 1..15: number of cycles the front end is held in flush after reset deasserts.

Ports:
- `clk`  in  1  single core clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rs1_addr_d_i`  in  REG_ADDR_WIDTH  Decode source register 1.
- `rs2_addr_d_i`  in  REG_ADDR_WIDTH  Decode source register 2.
- `rd_addr_e_i`  in  REG_ADDR_WIDTH  Execute destination register.
- `result_src_e_i`  in  2  Execute result select; `2'b01` = load.
- `pc_src_e_i`  in  1  taken branch or jump resolved in Execute.
- `halt_req_i`  in  1  debug halt request pulse.
- `resume_req_i`  in  1  debug resume request pulse.
- `step_req_i`  in  1  debug single-step request pulse.
- `stall_f_o`  out  1  hold the PC register.
- `stall_d_o`  out  1  hold the IF/ID register.
- `flush_d_o`  out  1  clear IF/ID to NOP.
- `flush_e_o`  out  1  clear ID/EX to bubble.
- `halted_o`  out  1  core front end is halted.
- `step_done_o`  out  1  one-cycle pulse when a single step completes.

## Operation
- States: `INIT`, `RUN`, `HALTED`, `STEP`. The state register and a 4-bit flush counter are reset asynchronously.
- `lw_stall` = (`result_src_e_i == 2'b01`) & (`rd_addr_e_i != 0`) & (`rd_addr_e_i` matches `rs1_addr_d_i` or `rs2_addr_d_i`) & !`pc_src_e_i`.
- `INIT`:
  - Outputs: `stall_f_o`=1, `flush_d_o`=1, `flush_e_o`=1, `stall_d_o`=0.
  - The counter loads `RESET_FLUSH_CYCLES` on reset and decrements each cycle.
  - Transition to `RUN` on the edge where the counter equals 1.
- `RUN` and `STEP` outputs:
  - `stall_f_o` = `stall_d_o` = `lw_stall`.
  - `flush_d_o` = `pc_src_e_i`.
  - `flush_e_o` = `lw_stall` | `pc_src_e_i`.
- Halt pending:
  - `halt_req_i` sets a `halt_pending` flag when in `RUN`; it is ignored in all other states.
  - `RUN`→`HALTED` happens on an edge where (`halt_pending` | `halt_req_i`) & !`lw_stall` & !`pc_src_e_i`.
  - Otherwise the halt waits until a clean cycle. `halt_pending` clears on entry to `HALTED`.
- `HALTED`:
  - Outputs: `stall_f_o`=1, `stall_d_o`=1, `flush_e_o`=1 (bubbles drain Execute onward), `flush_d_o`=0, `halted_o`=1.
  - Hazard inputs are ignored.
  - If `resume_req_i` → `RUN`; else if `step_req_i` → `STEP`. Resume has priority when both are asserted.
- `STEP`:
  - Stays in `STEP` while `lw_stall`=1.
  - Otherwise returns to `HALTED` next edge, and `step_done_o` is asserted for that first `HALTED` cycle. A redirect (`pc_src_e_i`) counts as the step completing.
  - `halt_req_i` and `resume_req_i` are ignored in `STEP`.
- Reset asserted in any state, including mid-step: immediate return to `INIT`; `halt_pending` and `step_done_o` are cleared.

## Timing
- Reset values:
  - `stall_f_o`=1, `flush_d_o`=1, `flush_e_o`=1.
  - `stall_d_o`=0, `halted_o`=0, `step_done_o`=0.
- Stall and flush outputs are combinational from the state register and same-cycle hazard inputs. There is zero-cycle latency from `pc_src_e_i` or `lw_stall` to the stall/flush outputs.
- `halted_o` and `step_done_o` are decoded from registered state only, with no combinational path from inputs.
- Halt latency: `halted_o` rises the cycle after the first clean edge at or after `halt_req_i`.
- Resume latency: `halted_o` falls the cycle after `resume_req_i`.
- A step with no hazard occupies exactly 1 `STEP` cycle. It is extended by 1 cycle per `lw_stall` cycle.
- The flush sequence takes exactly `RESET_FLUSH_CYCLES` cycles after `rst` falls.

## Configuration
- `PIPELINE_HAZARD_CTRL_DEBUG_EN` defined: full four-state machine as above.
- Not defined:
  - Only `INIT` and `RUN` exist.
  - `halt_req_i`, `resume_req_i` and `step_req_i` are ignored.
  - `halted_o` and `step_done_o` are tied to 0.
  - The `halt_pending` flag is not built.

## Test plan
- Reset release with `RESET_FLUSH_CYCLES`=2 → `flush_d_o`=`flush_e_o`=`stall_f_o`=1 for exactly 2 cycles, then all 0 with idle inputs.
- Load-use hazard: `result_src_e_i`=01, `rd_addr_e_i`=5, `rs2_addr_d_i`=5 → `stall_f_o`=`stall_d_o`=`flush_e_o`=1 in the same cycle. With `rd_addr_e_i`=0 → all 0.
- `pc_src_e_i`=1 together with a matching load condition → `flush_d_o`=`flush_e_o`=1, `stall_f_o`=`stall_d_o`=0.
- `halt_req_i` pulse during a `lw_stall` cycle → no halt that cycle; `halted_o`=1 one cycle after the first clean cycle. `stall_f_o`=`stall_d_o`=`flush_e_o`=1 while halted.
- In `HALTED`, `step_req_i` pulse → 1 cycle of `RUN`-style outputs, then `halted_o`=1 with a single `step_done_o` pulse. Asserting `step_req_i` and `resume_req_i` together → `RUN`, no `step_done_o`.
- Assert `rst` during `STEP` → all outputs at reset values immediately. Build without the macro → `halt_req_i` has no effect and `halted_o` stays 0.
